rr_decoder_arbiter: RTL
=======================

# rr_decoder_arbiter

Round-robin arbiter that shares one resource among 2**n requesters. It selects one requester, registers the winner's binary index and drives that index through the team's `decoder_generic` (n-to-2**n, enable-gated) to produce a one-hot grant. The grant is held until the owner releases it or a hold timeout fires. The block sits between requester ports and the shared resource's select/enable lines.

## Interface
- `n`, default 4: index width; requester count N = 2**n.
- `HOLD_MAX`, default 16: maximum cycles a grant may be held before forced release; legal range 1..255.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset. It is the only reset and is sampled on `clk`.
- `req`, input, [0:N-1]: request vector. Bit i belongs to requester i, and bit 0 is the MSB position, matching the decoder's `y` ordering.
- `done`, input, 1: the current owner releases the grant. Ignored when `gnt_valid` = 0.
- `gnt`, output, [0:N-1]: one-hot grant, all zeros when no grant is active.
- `gnt_idx`, output, [n-1:0]: binary index of the current or most recent winner.
- `gnt_valid`, output, 1: a grant is active.
- `timeout`, output, 1: one-cycle pulse when a grant is force-released.

## Operation
- FSM states:
  - IDLE: no grant active.
  - GRANT: a grant is held.
- Reset values: state = IDLE, `ptr` = 0, `hold_cnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `gnt` = all zeros, `timeout` = 0.
- IDLE, `req` ≠ 0:
  - Pick the first set bit scanning from `ptr` upward, wrapping N-1 → 0.
  - Register the winner into `gnt_idx`, set `gnt_valid` = 1, clear `hold_cnt`, go to GRANT.
- IDLE, `req` = 0: stay in IDLE; `gnt_idx` keeps its last value.
- GRANT: `hold_cnt` increments by 1 every cycle. Release conditions, checked in priority order:
  1. `done` = 1 → normal release.
  2. `req[gnt_idx]` = 0 → owner withdrew; normal release.
  3. `hold_cnt` = HOLD_MAX-1 → forced release; `timeout` = 1 on the cycle after.
- On any release:
  - `ptr` ← (`gnt_idx` + 1) mod N. This is an n-bit natural wrap, so N-1 → 0.
  - `gnt_valid` ← 0, state ← IDLE.
- `gnt` is combinational: `decoder_generic` with w = `gnt_idx` and en = `gnt_valid`. Exactly one bit is set when `gnt_valid` = 1, else all zeros.
- Round-robin guarantee: a continuously requesting requester is granted within N grants.
- Simultaneous requests: the rotating priority from `ptr` decides the winner. No fixed-priority bias beyond that.
- Requests that change while in GRANT have no effect until the state returns to IDLE, apart from the owner's own withdrawal.
- Reset mid-grant: the next cycle shows `gnt` = 0 and `gnt_valid` = 0, and the pointer returns to 0.

## Timing
- `req` sampled in IDLE at edge k → `gnt_valid`, `gnt_idx` and `gnt` valid after edge k, i.e. one-cycle latency.
- `done` sampled at edge m → `gnt` = 0 after edge m.
- Earliest next grant is after edge m+1. There is one mandatory IDLE bubble between grants.
- Forced release: a grant becomes visible after edge k, `hold_cnt` counts 0..HOLD_MAX-1, and the grant drops after edge k+HOLD_MAX.
- `timeout` is high for exactly one cycle, coincident with the first IDLE cycle after a forced release.
- `done` and the timeout condition in the same cycle → normal release, `timeout` stays 0.
- `hold_cnt` width is 8 bits and never exceeds HOLD_MAX-1.

## Structure
- Shared package/header `arb_pkg`:
  - state encodings (IDLE = 1'b0, GRANT = 1'b1);
  - the `HOLD_MAX` default;
  - the counter width constant (8).
- Sub-module `rr_pick`: combinational rotating priority encoder. Inputs are `req` and `ptr`; outputs are `any` and `idx [n-1:0]`. Implementation is rotate-by-`ptr`, find-first, un-rotate.
- Reuse the existing `decoder_generic #(.n(n))` unchanged for one-hot generation.
- Top level holds the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
Bench uses n=2 (N=4) and HOLD_MAX=4 unless noted.
- Reset: hold `rst` for 2 cycles with `req` = 4'b1111 → `gnt` = 0000, `gnt_valid` = 0, `gnt_idx` = 0. After release, the first grant is idx 0 (`gnt` = 1000).
- Rotation: `req` = 1111 held, `done` pulsed each GRANT cycle → `gnt_idx` sequence 0,1,2,3,0 with an IDLE cycle between each grant.
- Wrap and skip: `ptr` = 3 after a grant to idx 2, then `req` = 0100 (requester 1 only) → grant idx 1 (`gnt` = 0100); `ptr` then becomes 2.
- Timeout: `req` = 0010 held, `done` = 0 → grant to idx 2 for exactly 4 cycles, then `gnt` = 0000 and `timeout` = 1 for one cycle. The next grant is idx 2 again, since it is the only requester.
- Withdrawal and simultaneous events: owner idx 1 drops `req` → release next cycle with `timeout` = 0. In a separate run, `done` = 1 on the HOLD_MAX-1 cycle → `timeout` stays 0.
- Reset mid-grant: assert `rst` while idx 3 is granted → `gnt` = 0000 next cycle. After reset with `req` = 1111, the first grant is idx 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decoder arbiter.
package arb_pkg;

    // FSM state encoding.
    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Default maximum hold time in cycles before a grant is forced off.
    localparam int unsigned HoldMaxDefault = 16;

    // Width of the hold counter; HOLD_MAX must fit below 2**CntWidth.
    localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/decoder_generic.sv
// Generic n-to-2**n enable-gated decoder. Output bit 0 is the MSB position.
module decoder_generic #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0]      w,
    input  logic              en,
    output logic [0:(2**n)-1] y
);

    // One-hot select of output w when enabled, all zeros otherwise.
    always_comb begin
        y = '0;
        if (en) begin
            y[w] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned n = 4
) (
    input  logic [0:(2**n)-1] req,
    input  logic [n-1:0]      ptr,
    output logic              any,
    output logic [n-1:0]      idx
);

    localparam int unsigned N = 2 ** n;

    logic [0:N-1] rot;
    logic [n-1:0] off;

    // Rotate so that position 0 of rot is requester ptr.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[ptr + n'(k)];
        end
    end

    // Find the first set bit of the rotated vector, then un-rotate by ptr.
    always_comb begin
        any = 1'b0;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                off = n'(k);
            end
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with held, timeout-limited grants and a one-hot
// grant produced by decoder_generic from the registered winner index.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned n        = 4,
    parameter int unsigned HOLD_MAX = HoldMaxDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:(2**n)-1] req,
    input  logic              done,
    output logic [0:(2**n)-1] gnt,
    output logic [n-1:0]      gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_MAX - 1);

    arb_state_e          state_q;
    logic [n-1:0]        ptr_q;
    logic [CntWidth-1:0] hold_cnt_q;
    logic [n-1:0]        gnt_idx_q;
    logic                gnt_valid_q;
    logic                timeout_q;

    logic                pick_any;
    logic [n-1:0]        pick_idx;
    logic                rel_done;
    logic                rel_withdraw;
    logic                rel_force;

    rr_pick #(
        .n(n)
    ) u_pick (
        .req(req),
        .ptr(ptr_q),
        .any(pick_any),
        .idx(pick_idx)
    );

    // Release causes in priority order; a forced release only when neither
    // normal release applies, so timeout never fires alongside done.
    always_comb begin
        rel_done     = done;
        rel_withdraw = !done && !req[gnt_idx_q];
        rel_force    = !done && req[gnt_idx_q] && (hold_cnt_q == HoldLast);
    end

    // Arbitration FSM with registered index, valid and timeout outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        gnt_idx_q   <= pick_idx;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                        state_q     <= StGrant;
                    end
                end
                StGrant: begin
                    if (rel_done || rel_withdraw || rel_force) begin
                        // Counter is cleared rather than advanced past HOLD_MAX-1.
                        hold_cnt_q  <= '0;
                        ptr_q       <= gnt_idx_q + 1'b1;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= rel_force;
                        state_q     <= StIdle;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    decoder_generic #(
        .n(n)
    ) u_dec (
        .w(gnt_idx_q),
        .en(gnt_valid_q),
        .y(gnt)
    );

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
